// File: rtl/qpsk_tx_shaper.sv
// QPSK single-rail transmit shaper: PRBS9 or external bit source, +/-1 mapping,
// x4 upsampling and 24-tap polyphase pulse shaping to a signed 8-bit sample stream.
module qpsk_tx_shaper #(
    parameter logic [191:0] COEF = {8'h00, 8'hfe, 8'hff, 8'h00, 8'h02, 8'h00, 8'hfb, 8'hf5,
                                    8'hf9, 8'h0a, 8'h25, 8'h3e, 8'h48, 8'h3e, 8'h25, 8'h0a,
                                    8'hf9, 8'hf5, 8'hfb, 8'h00, 8'h02, 8'h00, 8'hff, 8'hfe},
    parameter logic [8:0]   PRBS_SEED = 9'h1AA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       i_sel_prbs,
    input  logic       i_bit,
    output logic       o_bit_req,
    output logic       o_bit,
    output logic       o_bit_valid,
    output logic [7:0] o_tx
);

    localparam int unsigned N_PH   = 4;
    localparam int unsigned N_SYM  = 6;
    localparam int unsigned COEF_W = 8;
    localparam int unsigned ACC_W  = 11;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned PRBS_W = 9;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned COEF_MSB = N_SYM * N_PH * COEF_W - 1;

    // An all-zero seed would lock the LFSR, so substitute all-ones.
    localparam logic [PRBS_W-1:0] SEED = (PRBS_SEED == '0) ? PRBS_W'(9'h1FF) : PRBS_SEED;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (OUT_W - 1)));

    // Coefficients regrouped as [symbol slot][phase]: tap index = 4*slot + phase.
    logic signed [COEF_W-1:0] coef_ph [N_SYM][N_PH];

    for (genvar k = 0; k < N_SYM; k++) begin : g_slot
        for (genvar p = 0; p < N_PH; p++) begin : g_phase
            assign coef_ph[k][p] = COEF[COEF_MSB - COEF_W * (N_PH * k + p) -: COEF_W];
        end
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PRBS_W-1:0] prbs_q, prbs_d;
    logic [N_SYM-1:0]  sym_q, sym_d;
    logic [N_SYM-1:0]  vld_q, vld_d;
    logic [OUT_W-1:0]  tx_q, tx_d;
    logic              bit_q, bit_d;
    logic              bit_valid_q, bit_valid_d;

    logic                    load_c;
    logic                    bit_src_c;
    logic signed [ACC_W-1:0] acc_c;

    assign load_c    = enable && (cnt_q == '0);
    assign bit_src_c = i_sel_prbs ? prbs_q[PRBS_W-1] : i_bit;

    // Next-state: phase counter, symbol shift register, PRBS and bit reference.
    always_comb begin
        cnt_d       = cnt_q;
        prbs_d      = prbs_q;
        sym_d       = sym_q;
        vld_d       = vld_q;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;

        if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (load_c) begin
            sym_d       = {sym_q[N_SYM-2:0], bit_src_c};
            vld_d       = {vld_q[N_SYM-2:0], 1'b1};
            bit_d       = bit_src_c;
            bit_valid_d = 1'b1;
            if (i_sel_prbs) begin
                prbs_d = {prbs_q[PRBS_W-2:0], prbs_q[8] ^ prbs_q[4]};
            end
        end
    end

    // Polyphase FIR on the post-shift symbols: +/-coef per valid slot, no multipliers.
    always_comb begin
        acc_c = '0;
        for (int k = 0; k < N_SYM; k++) begin
            if (vld_d[k]) begin
                if (sym_d[k]) begin
                    acc_c = acc_c + ACC_W'(coef_ph[k][cnt_q]);
                end else begin
                    acc_c = acc_c - ACC_W'(coef_ph[k][cnt_q]);
                end
            end
        end
    end

    always_comb begin
        tx_d = tx_q;
        if (enable) begin
            if (acc_c > SAT_HI) begin
                tx_d = OUT_W'(SAT_HI);
            end else if (acc_c < SAT_LO) begin
                tx_d = OUT_W'(SAT_LO);
            end else begin
                tx_d = acc_c[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            prbs_q      <= SEED;
            sym_q       <= '0;
            vld_q       <= '0;
            tx_q        <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prbs_q      <= prbs_d;
            sym_q       <= sym_d;
            vld_q       <= vld_d;
            tx_q        <= tx_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign o_bit_req   = enable & (cnt_q == '0) & ~i_sel_prbs;
    assign o_bit       = bit_q;
    assign o_bit_valid = bit_valid_q;
    assign o_tx        = tx_q;

endmodule

// File: tb/tb_qpsk_tx_shaper.sv
// Self-checking bench for qpsk_tx_shaper: directed vector table, steady-state
// patterns, PRBS sequence/period, random enable gating and mid-stream reset.
module tb_qpsk_tx_shaper;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       i_sel_prbs;
    logic       i_bit;
    logic       o_bit_req;
    logic       o_bit;
    logic       o_bit_valid;
    logic [7:0] o_tx;

    qpsk_tx_shaper dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .i_sel_prbs (i_sel_prbs),
        .i_bit      (i_bit),
        .o_bit_req  (o_bit_req),
        .o_bit      (o_bit),
        .o_bit_valid(o_bit_valid),
        .o_tx       (o_tx)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    logic req_seen;

    typedef struct {
        logic en;
        logic b;
        logic req;
        int   tx;
        logic vld;
        logic bo;
    } vec_t;

    vec_t vecs[13];

    int coef_tab[24] = '{0, -2, -1, 0, 2, 0, -5, -11, -7, 10, 37, 62,
                         72, 62, 37, 10, -7, -11, -5, 0, 2, 0, -1, -2};
    int ones_pat[4]  = '{62, 59, 62, 59};
    int single_pat[4] = '{0, -2, -1, 0};
    logic first_bits[3] = '{1'b1, 1'b1, 1'b0};

    // Reference model state
    logic [8:0] m_st;
    logic       m_sym[6];
    logic       m_vld[6];
    int         m_cnt;
    int         m_last_tx;
    logic       m_last_bit;

    logic dut_bits[520];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int txv();
        return int'($signed(o_tx));
    endfunction

    // One clock: drive inputs, capture the combinational request, sample after the edge.
    task automatic cyc(input logic r, input logic en, input logic sel, input logic b);
        rst        = r;
        enable     = en;
        i_sel_prbs = sel;
        i_bit      = b;
        #1;
        req_seen = o_bit_req;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_st       = 9'h1AA;
        m_cnt      = 0;
        m_last_tx  = 0;
        m_last_bit = 1'b0;
        for (int k = 0; k < 6; k++) begin
            m_sym[k] = 1'b0;
            m_vld[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic sel, input logic b,
                              output int tx, output logic ld, output logic bo);
        int acc;
        ld = (m_cnt == 0);
        bo = m_last_bit;
        if (ld) begin
            bo = sel ? m_st[8] : b;
            for (int k = 5; k > 0; k--) begin
                m_sym[k] = m_sym[k-1];
                m_vld[k] = m_vld[k-1];
            end
            m_sym[0] = bo;
            m_vld[0] = 1'b1;
            if (sel) m_st = {m_st[7:0], m_st[8] ^ m_st[4]};
        end
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (m_vld[k]) acc += m_sym[k] ? coef_tab[4*k + m_cnt] : -coef_tab[4*k + m_cnt];
        end
        tx = (acc > 127) ? 127 : ((acc < -128) ? -128 : acc);
        m_cnt      = (m_cnt + 1) % 4;
        m_last_tx  = tx;
        m_last_bit = bo;
    endtask

    function automatic vec_t mk(input logic en, input logic b, input logic req,
                                input int tx, input logic vld, input logic bo);
        vec_t v;
        v.en = en; v.b = b; v.req = req; v.tx = tx; v.vld = vld; v.bo = bo;
        return v;
    endfunction

    initial begin
        int   etx;
        logic ld;
        logic eb;
        int   nb;
        int   req_hits;
        int   n;
        logic en;

        vecs[0]  = mk(1'b1, 1'b1, 1'b1,   0, 1'b1, 1'b1);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0,  -2, 1'b0, 1'b1);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0,  -1, 1'b0, 1'b1);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0,   0, 1'b0, 1'b1);
        vecs[4]  = mk(1'b1, 1'b1, 1'b1,   2, 1'b1, 1'b1);
        vecs[5]  = mk(1'b1, 1'b1, 1'b0,  -2, 1'b0, 1'b1);
        vecs[6]  = mk(1'b1, 1'b1, 1'b0,  -6, 1'b0, 1'b1);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, -11, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, -11, 1'b0, 1'b1);
        vecs[9]  = mk(1'b1, 1'b0, 1'b1,  -5, 1'b1, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 1'b0,  12, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 1'b0,  33, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 1'b0,  51, 1'b0, 1'b0);

        // Reset wins over enable
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("reset_tx", txv(), 0);
        chk("reset_bit", int'(o_bit), 0);
        chk("reset_valid", int'(o_bit_valid), 0);

        // Directed vector table, external bits
        for (int i = 0; i < 13; i++) begin
            cyc(1'b0, vecs[i].en, 1'b0, vecs[i].b);
            chk($sformatf("vec%0d_req", i), int'(req_seen), int'(vecs[i].req));
            chk($sformatf("vec%0d_tx", i), txv(), vecs[i].tx);
            chk($sformatf("vec%0d_valid", i), int'(o_bit_valid), int'(vecs[i].vld));
            chk($sformatf("vec%0d_bit", i), int'(o_bit), int'(vecs[i].bo));
        end

        // Steady all-ones then all-zeros
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int e = 1; e <= 64; e++) begin
            cyc(1'b0, 1'b1, 1'b0, (e <= 32) ? 1'b1 : 1'b0);
            if (e > 24 && e <= 32) chk("ones_tx", txv(), ones_pat[(e-1) % 4]);
            if (e > 56) chk("zeros_tx", txv(), -ones_pat[(e-1) % 4]);
        end

        // PRBS run with enable always high
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        model_reset();
        nb = 0;
        req_hits = 0;
        for (int e = 0; e < 2080; e++) begin
            model_step(1'b1, 1'b0, etx, ld, eb);
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            if (req_seen) req_hits++;
            chk("prbs_tx", txv(), etx);
            chk("prbs_valid", int'(o_bit_valid), int'(ld));
            if (ld) begin
                chk("prbs_bit", int'(o_bit), int'(eb));
                dut_bits[nb] = o_bit;
                nb++;
            end
        end
        chk("prbs_req_never", req_hits, 0);
        chk("prbs_symbols", nb, 520);
        for (int i = 0; i < 3; i++) chk("prbs_first_bits", int'(dut_bits[i]), int'(first_bits[i]));
        for (int i = 0; i < 9; i++) chk("prbs_period", int'(dut_bits[i+511]), int'(dut_bits[i]));

        // Random enable gating in PRBS mode
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        model_reset();
        n = 0;
        for (int c = 0; c < 1200 && n < 200; c++) begin
            en = 1'($urandom_range(0, 1));
            if (en) begin
                model_step(1'b1, 1'b0, etx, ld, eb);
                cyc(1'b0, 1'b1, 1'b1, 1'b0);
                chk("gate_tx", txv(), etx);
                chk("gate_valid", int'(o_bit_valid), int'(ld));
                chk("gate_bit", int'(o_bit), int'(eb));
                n++;
            end else begin
                cyc(1'b0, 1'b0, 1'b1, 1'b0);
                chk("idle_tx_hold", txv(), m_last_tx);
                chk("idle_valid", int'(o_bit_valid), 0);
                chk("idle_bit_hold", int'(o_bit), int'(m_last_bit));
                chk("idle_req", int'(req_seen), 0);
            end
        end
        chk("gate_budget", n, 200);

        // Mid-stream reset with enable high
        for (int e = 0; e < 10; e++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("midrst_tx", txv(), 0);
        chk("midrst_valid", int'(o_bit_valid), 0);
        chk("midrst_bit", int'(o_bit), 0);
        for (int e = 0; e < 12; e++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            if (e < 4) chk("midrst_single_tx", txv(), single_pat[e]);
            chk("midrst_valid_seq", int'(o_bit_valid), (e % 4 == 0) ? 1 : 0);
            if (e % 4 == 0) chk("midrst_bits", int'(o_bit), int'(first_bits[e/4]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qpsk_tx_shaper.md
Name: qpsk_tx_shaper

Overview:
- Transmit branch of one QPSK I or Q rail; it is the counterpart of the matched-filter receiver.
- Takes one bit per symbol from an internal PRBS9 source or from an external bit port, and maps it to ±1.
- Upsamples ×4 and pulse-shapes with a 24-tap, 4-phase polyphase FIR.
- Produces one signed 8-bit sample per `enable` tick for the channel or DAC. The consumed bit is also output as a BER reference.

Parameters:
- COEF, 192-bit vector = {8'h00,8'hfe,8'hff,8'h00,8'h02,8'h00,8'hfb,8'hf5,8'hf9,8'h0a,8'h25,8'h3e,8'h48,8'h3e,8'h25,8'h0a,8'hf9,8'hf5,8'hfb,8'h00,8'h02,8'h00,8'hff,8'hfe}: tap coefficients. coef[j] = COEF[191-8j -: 8], signed.
- PRBS_SEED, 9'h1AA: PRBS9 state at reset. A value of 0 is illegal; 9'h1FF is loaded instead.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- enable  in  1  sample-rate tick; one output sample per high cycle
- i_sel_prbs  in  1  1 = bits come from internal PRBS9; 0 = bits come from i_bit
- i_bit  in  1  external data bit; sampled only when o_bit_req = 1
- o_bit_req  out  1  combinational strobe: enable & (cnt==0) & ~i_sel_prbs
- o_bit  out  1  registered copy of the last consumed bit
- o_bit_valid  out  1  one-cycle pulse, registered, the cycle after a bit is consumed
- o_tx  out  8  signed shaped sample, registered

Behaviour:
- Reset (rst=1 at a clock edge): all of the following regardless of enable.
  - cnt = 0; PRBS state = PRBS_SEED; sym[5:0] = 0; vld[5:0] = 0.
  - o_tx = 0; o_bit = 0; o_bit_valid = 0.
  - Reset mid-operation discards all symbols in flight.
- enable = 0: all registers hold; o_bit_valid = 0; o_bit_req = 0.
- Phase counter cnt (2 bits): increments on each enable and wraps 3→0.
- Symbol load, on an enable cycle with cnt==0:
  - Bit source: b = PRBS state[8] if i_sel_prbs, else i_bit.
  - Shift: sym[5:1] <= sym[4:0]; sym[0] <= b; vld <= {vld[4:0],1}.
  - PRBS advances only when it is the selected source: state <= {state[7:0], state[8]^state[4]}. When not selected it holds.
  - o_bit <= b; o_bit_valid <= 1.
  - A change of i_sel_prbs takes effect at the next load only.
- Symbol mapping: bit 1 → +1, bit 0 → −1. An entry with vld=0 contributes 0.
- Sample computation on every enable:
  - Let s'/v' be the symbol/valid values being written this cycle (the shifted values when cnt==0, otherwise the current ones).
  - acc = Σ k=0..5 of (v'[k] ? (s'[k] ? +coef[4k+cnt] : −coef[4k+cnt]) : 0).
  - Implementation is add/subtract only; no multipliers.
  - acc is 11-bit signed; o_tx <= acc saturated to [−128,127].
  - With the default COEF, |acc| ≤ 90, so saturation never triggers.
- Latency: a loaded symbol first appears in o_tx one clock after its load enable, weighted by coef[0]. Its four samples use coef[0..3], then coef[4..7] after the next load, and so on through coef[23].
- Steady all-ones output per phase cnt=0..3: 62, 59, 62, 59. All-zeros gives the negation.
- The sign convention matches the receiver: positive filtered sample ↔ bit 1.

Test Plan:
- Reset, then 4 enables with i_sel_prbs=0, i_bit=1: o_bit_req pulses on enable 1 only; o_bit_valid pulses one cycle later with o_bit=1; o_tx sequence = 0, −2, −1, 0 (only sym[0] valid).
- Continue with i_bit=1 for the 5th enable: o_tx = 2, then −2, −6, −11 across enables 5–8.
- External all-ones for ≥ 24 enables: o_tx settles to the repeating pattern 62, 59, 62, 59. Switch to all-zeros: after 24 more enables the pattern is −62, −59, −62, −59.
- i_sel_prbs=1 from reset with default seed: o_bit sequence starts 1, 1, 0, one bit per 4 enables, and the sequence period is 511 symbols. o_bit_req stays 0 throughout.
- Toggle enable pseudo-randomly (about 50 %) during PRBS mode: the o_tx and o_bit sequences equal the enable-always-high run sample-for-sample; all outputs hold while enable=0.
- Assert rst for one cycle mid-stream with enable=1: the next cycle shows o_tx=0, o_bit_valid=0 and cnt=0. The PRBS restarts, so the bits again begin 1, 1, 0, and the first post-reset samples repeat the 0, −2, −1, 0 single-symbol response.
